// File: rtl/sprite_position_ctrl.sv
// sprite_position_ctrl: turns the four raw active-low push-buttons into a
// clamped sprite origin for the VGA overlay. Keys are synchronized and
// debounced, a shared repeat FSM issues a first-press step followed by
// tick-paced auto-repeat, and the position saturates so the sprite square
// always stays inside the active area. Everything runs on the pixel clock.
`timescale 1ns/1ps

module sprite_position_ctrl #(
    parameter int TICK_DIV        = 1000000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 8,
    parameter int STEP            = 10,
    parameter int SPRITE_SIZE     = 50,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int X_INIT          = 100,
    parameter int Y_INIT          = 100
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        moveleft,
    input  logic        moveright,
    input  logic        moveup,
    input  logic        movedown,
    output logic [11:0] oXPOS,
    output logic [11:0] oYPOS,
    output logic        oTICK,
    output logic        oMOVING
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_DELAY + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LOAD  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    localparam logic signed [12:0] STEP_S = 13'(STEP);
    localparam logic signed [12:0] X_MAX  = 13'(H_ACTIVE - SPRITE_SIZE);
    localparam logic signed [12:0] Y_MAX  = 13'(V_ACTIVE - SPRITE_SIZE);
    localparam logic [11:0]        X_MAX_U = 12'(H_ACTIVE - SPRITE_SIZE);
    localparam logic [11:0]        Y_MAX_U = 12'(V_ACTIVE - SPRITE_SIZE);

    // Key bit order used throughout: 0 left, 1 right, 2 up, 3 down.
    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_UP    = 2;
    localparam int K_DOWN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    logic [3:0]            key_raw;
    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0]            stable_q, stable_d;
    logic [3:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    state_t                state_q, state_d;
    logic [11:0]           xpos_q, xpos_d;
    logic [11:0]           ypos_q, ypos_d;
    logic                  moving_q, moving_d;

    logic [3:0]            pressed;
    logic                  any_key;
    logic                  tick;
    logic                  step;
    logic signed [12:0]    dx, dy;
    logic signed [12:0]    x_sum, y_sum;
    logic [11:0]           x_next, y_next;

    assign key_raw = {movedown, moveup, moveright, moveleft};
    assign pressed = ~stable_q;
    assign any_key = |pressed;
    assign tick    = (tick_cnt_q == TICK_LAST);

    assign oXPOS   = xpos_q;
    assign oYPOS   = ypos_q;
    assign oTICK   = tick;
    assign oMOVING = moving_q;

    // Two-flop synchronizer on the raw keys plus debounce of the synced value.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (sync2_q[k] != stable_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    stable_d[k] = sync2_q[k];
                    db_cnt_d[k] = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end else begin
                db_cnt_d[k] = '0;
            end
        end
    end

    // Free-running movement tick divider.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Repeat FSM next-state: first-press step, hold-off, then tick-paced repeat.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        step      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_key) begin
                    step      = 1'b1;
                    rep_cnt_d = REP_LOAD;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!any_key) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (rep_cnt_q == REP_ONE) begin
                        rep_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end else begin
                        rep_cnt_d = rep_cnt_q - 1'b1;
                    end
                end
            end
            ST_REPEAT: begin
                if (!any_key) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step direction, signed add and saturation to the legal origin range.
    always_comb begin
        dx = '0;
        dy = '0;
        if (pressed[K_RIGHT] && !pressed[K_LEFT]) dx = STEP_S;
        else if (pressed[K_LEFT] && !pressed[K_RIGHT]) dx = -STEP_S;
        if (pressed[K_DOWN] && !pressed[K_UP]) dy = STEP_S;
        else if (pressed[K_UP] && !pressed[K_DOWN]) dy = -STEP_S;

        x_sum = $signed({1'b0, xpos_q}) + dx;
        y_sum = $signed({1'b0, ypos_q}) + dy;

        if (x_sum[12])          x_next = '0;
        else if (x_sum > X_MAX) x_next = X_MAX_U;
        else                    x_next = x_sum[11:0];

        if (y_sum[12])          y_next = '0;
        else if (y_sum > Y_MAX) y_next = Y_MAX_U;
        else                    y_next = y_sum[11:0];

        xpos_d   = step ? x_next : xpos_q;
        ypos_d   = step ? y_next : ypos_q;
        moving_d = step && ((x_next != xpos_q) || (y_next != ypos_q));
    end

    // FSM state register.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    // Datapath registers: key pipeline, divider and sprite position.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '1;
            db_cnt_q   <= '0;
            tick_cnt_q <= '0;
            xpos_q     <= 12'(X_INIT);
            ypos_q     <= 12'(Y_INIT);
            moving_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            moving_q   <= moving_d;
        end
    end

endmodule
